// File: rtl/addsub_iter_sat.sv
// -----------------------------------------------------------------------------
// addsub_iter_sat
// Multi-cycle saturating signed adder/subtractor. It shares one CHUNK-bit
// adder slice across WIDTH/CHUNK clock cycles. Results and Z/V/N flags are
// registered so they can feed the flag register directly.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      operation request, sampled only while not busy
//   A      in   WIDTH  signed operand A
//   B      in   WIDTH  signed operand B
//   Sub    in   1      1: A-B, 0: A+B
//   busy   out  1      high from the accept edge until the done cycle
//   done   out  1      one-cycle pulse; Sum/flags are valid from this cycle
//   Sum    out  WIDTH  saturated result, held until the next done
//   Z      out  1      Sum == 0
//   V      out  1      signed overflow occurred (Sum saturated)
//   N      out  1      Sum sign bit
//
// WIDTH must be a multiple of CHUNK with at least two chunks.
// -----------------------------------------------------------------------------
module addsub_iter_sat #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Z,
    output logic             V,
    output logic             N
);

    localparam int ITER = WIDTH / CHUNK;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Clamp to the extreme of the side operand A was on when overflow occurred.
    function automatic logic [WIDTH-1:0] sat_fn(
        input logic [WIDTH-1:0] raw,
        input logic             ovf,
        input logic             a_neg
    );
        logic [WIDTH-1:0] res;
        if (!ovf) begin
            res = raw;
        end else if (a_neg) begin
            res = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            res = {1'b0, {(WIDTH-1){1'b1}}};
        end
        return res;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] opa_r, opb_r, psum_r;
    logic             carry_r;
    logic             a_neg_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] sum_r;
    logic             z_r, v_r, n_r, busy_r, done_r;

    logic [CHUNK:0]   slice_s;
    logic [WIDTH-1:0] raw_s;
    logic [WIDTH-1:0] sat_s;
    logic             last_s, c_msb_in_s, c_msb_out_s, v_s;
    logic             load_s, finish_s;

    // Adder slice and final-chunk overflow/saturation logic.
    // Operands shift right each step, so the active slice is always the low
    // CHUNK bits; the partial sum fills in from the top.
    always_comb begin
        slice_s = {1'b0, opa_r[CHUNK-1:0]} + {1'b0, opb_r[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, carry_r};
        last_s  = (cnt_r == CW'(ITER - 1));
        raw_s   = {slice_s[CHUNK-1:0], psum_r[WIDTH-1:CHUNK]};
        // Carry into the MSB recovered from the MSB sum bit and its operands.
        c_msb_in_s  = slice_s[CHUNK-1] ^ opa_r[CHUNK-1] ^ opb_r[CHUNK-1];
        c_msb_out_s = slice_s[CHUNK];
        v_s         = c_msb_in_s ^ c_msb_out_s;
        sat_s       = sat_fn(raw_s, v_s, a_neg_r);
    end

    // Next-state and control decode.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s      = 1'b1;
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    finish_s    = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE: begin
                if (start) begin
                    load_s      = 1'b1;
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand latch and iterative datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_r   <= {WIDTH{1'b0}};
            opb_r   <= {WIDTH{1'b0}};
            psum_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            a_neg_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else if (load_s) begin
            // Subtraction as A + ~B + 1: invert here, the +1 is the carry-in.
            opa_r   <= A;
            opb_r   <= B ^ {WIDTH{Sub}};
            psum_r  <= {WIDTH{1'b0}};
            carry_r <= Sub;
            a_neg_r <= A[WIDTH-1];
            cnt_r   <= {CW{1'b0}};
        end else if (state_r == CALC) begin
            opa_r   <= opa_r >> CHUNK;
            opb_r   <= opb_r >> CHUNK;
            psum_r  <= raw_s;
            carry_r <= slice_s[CHUNK];
            cnt_r   <= cnt_r + CW'(1);
        end else begin
            opa_r   <= opa_r;
            opb_r   <= opb_r;
            psum_r  <= psum_r;
            carry_r <= carry_r;
            a_neg_r <= a_neg_r;
            cnt_r   <= cnt_r;
        end
    end

    // Result/flag registers (updated only at the final-chunk edge) and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r  <= {WIDTH{1'b0}};
            z_r    <= 1'b0;
            v_r    <= 1'b0;
            n_r    <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (finish_s) begin
                sum_r <= sat_s;
                z_r   <= (sat_s == {WIDTH{1'b0}});
                v_r   <= v_s;
                n_r   <= sat_s[WIDTH-1];
            end else begin
                sum_r <= sum_r;
                z_r   <= z_r;
                v_r   <= v_r;
                n_r   <= n_r;
            end
            busy_r <= (state_nxt_s == CALC);
            done_r <= (state_nxt_s == DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign Sum  = sum_r;
    assign Z    = z_r;
    assign V    = v_r;
    assign N    = n_r;

endmodule

// File: tb/tb_addsub_iter_sat.sv
module tb_addsub_iter_sat;

    localparam int W    = 16;
    localparam int C    = 4;
    localparam int ITER = W / C;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Sub;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Z;
    logic         V;
    logic         N;

    addsub_iter_sat #(.WIDTH(W), .CHUNK(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Sub   (Sub),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Z     (Z),
        .V     (V),
        .N     (N)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         z;
        logic         v;
        logic         n;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   fails    = 0;
    int   done_cnt = 0;
    int   issued   = 0;
    int   cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: exact integer arithmetic, clamped to the signed 16-bit range.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t        e;
        int          ai;
        int          bi;
        int          r;
        logic [31:0] rv;
        ai = $signed(a);
        bi = $signed(b);
        r  = s ? (ai - bi) : (ai + bi);
        if (r > 32767) begin
            e.sum = 16'h7FFF;
            e.v   = 1'b1;
        end else if (r < -32768) begin
            e.sum = 16'h8000;
            e.v   = 1'b1;
        end else begin
            rv    = r;
            e.sum = rv[15:0];
            e.v   = 1'b0;
        end
        e.z = (e.sum == 16'h0000);
        e.n = e.sum[15];
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL spurious_done: done=1 with no outstanding request (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                chk("sum", 32'(Sum), 32'(e.sum));
                chk("z",   32'(Z),   32'(e.z));
                chk("v",   32'(V),   32'(e.v));
                chk("n",   32'(N),   32'(e.n));
            end
        end
    end

    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int k;
        k = 0;
        while (busy && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        A = a; B = b; Sub = s; start = 1'b1;
        exp_q.push_back(model(a, b, s));
        issued++;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        wait_done(k);
        chk("latency", 32'(k), 32'(ITER));
    endtask

    logic [W-1:0] corners[6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};

    initial begin
        int k;
        int t1;
        int t2;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Sub = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(Sum),  32'd0);
        chk("rst_flags", {29'd0, Z, V, N}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_op(16'h1234, 16'h1111, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1);
        do_op(16'h0005, 16'h0005, 1'b1);
        do_op(16'h0000, 16'h8000, 1'b1);
        do_op(16'hFFFF, 16'h8000, 1'b1);

        // Start and operand changes during CALC are ignored
        A = 16'h0001; B = 16'h0002; Sub = 1'b0; start = 1'b1;
        exp_q.push_back(model(16'h0001, 16'h0002, 1'b0));
        issued++;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        A = 16'h5555; B = 16'h7777; Sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(k);
        chk("midcalc_done_seen", 32'(done), 32'd1);
        repeat (8) @(posedge clk);
        #1;

        // Start held high through DONE: back-to-back acceptance
        A = 16'h0100; B = 16'h0200; Sub = 1'b0; start = 1'b1;
        exp_q.push_back(model(16'h0100, 16'h0200, 1'b0));
        issued++;
        @(posedge clk); #1;
        A = 16'hFFFF; B = 16'h0001; Sub = 1'b0;
        exp_q.push_back(model(16'hFFFF, 16'h0001, 1'b0));
        issued++;
        wait_done(k);
        t1 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(k);
        t2 = cyc;
        chk("b2b_spacing", 32'(t2 - t1), 32'(ITER + 1));
        @(posedge clk); #1;

        // Reset in the middle of CALC aborts everything
        do_op(16'h8000, 16'h0001, 1'b1);
        @(posedge clk); #1;
        A = 16'h4000; B = 16'h1000; Sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum",  32'(Sum),  32'd0);
        chk("abort_flags", {29'd0, Z, V, N}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt), 32'(issued));
        do_op(16'h1234, 16'h1111, 1'b0);

        // Randomized operations with corner-value bias
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
            do_op(ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(done_cnt), 32'(issued));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
